// File: rtl/penc_sync.sv
// Synchronised, debounced priority encoder with a valid/ready event output and sticky overflow.
// Defining PENC_ROUND_ROBIN_EN rotates the search pointer after each accepted event.
module penc_sync #(
    parameter int N        = 10,
    parameter int DEBOUNCE = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N-1:0]               i,
    output logic [$clog2(N+1)-1:0]     o,
    output logic                       any,
    output logic                       evt_valid,
    output logic [$clog2(N+1)-1:0]     evt_code,
    input  logic                       evt_ready,
    output logic                       ovf,
    input  logic                       ovf_clr
);

    localparam int W  = $clog2(N + 1);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [W-1:0]  NONE     = '1;
    localparam logic [W-1:0]  P_TOP    = W'(N - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    logic [N-1:0]  r_sync1;
    logic [N-1:0]  r_s;
    logic [N-1:0]  r_stable;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_o;
    logic          r_any;
    logic          r_evt_valid;
    logic [W-1:0]  r_evt_code;
    logic          r_ovf;

    logic [W-1:0]  w_p;
    logic [N-1:0]  w_le_p;
    logic [N-1:0]  w_low;
    logic [W-1:0]  w_hi_low;
    logic [W-1:0]  w_hi_all;
    logic [W-1:0]  w_code;
    logic          w_new_evt;
    logic          w_hs;

    // r_cnt counts how many cycles s has matched its previous value; comparing
    // r_sync1 against r_s looks one sample ahead so stable loads on the edge
    // the count completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= '0;
            r_s      <= '0;
            r_stable <= '0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i;
            r_s     <= r_sync1;
            if (r_sync1 != r_s) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if ((r_sync1 == r_s) && (r_cnt == CNT_LAST)) begin
                r_stable <= r_s;
            end
        end
    end

`ifdef PENC_ROUND_ROBIN_EN
    logic [W-1:0] r_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p <= P_TOP;
        end else if (w_hs) begin
            r_p <= (r_evt_code == '0) ? P_TOP : (r_evt_code - 1'b1);
        end
    end

    assign w_p = r_p;
`else
    assign w_p = P_TOP;
`endif

    // Downward search from p with wrap = highest set bit at or below p,
    // otherwise the highest set bit overall (which then lies above p).
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_mask
            assign w_le_p[gi] = (W'(gi) <= w_p);
        end
    endgenerate

    assign w_low = r_stable & w_le_p;

    always_comb begin
        w_hi_low = NONE;
        w_hi_all = NONE;
        for (int j = 0; j < N; j++) begin
            if (w_low[j]) begin
                w_hi_low = W'(j);
            end
            if (r_stable[j]) begin
                w_hi_all = W'(j);
            end
        end
    end

    assign w_code    = (w_hi_low != NONE) ? w_hi_low : w_hi_all;
    assign w_new_evt = (w_code != r_o) && (w_code != NONE);
    assign w_hs      = r_evt_valid & evt_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_o         <= NONE;
            r_any       <= 1'b0;
            r_evt_valid <= 1'b0;
            r_evt_code  <= NONE;
            r_ovf       <= 1'b0;
        end else begin
            r_o   <= w_code;
            r_any <= |r_stable;
            if (w_new_evt && (!r_evt_valid || w_hs)) begin
                r_evt_code  <= w_code;
                r_evt_valid <= 1'b1;
            end else if (w_hs) begin
                r_evt_valid <= 1'b0;
            end
            // A drop in the same cycle as a clear keeps the flag set.
            if (w_new_evt && r_evt_valid && !w_hs) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign o         = r_o;
    assign any       = r_any;
    assign evt_valid = r_evt_valid;
    assign evt_code  = r_evt_code;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_penc_sync.sv
// Bench for penc_sync: sample-history reference model checked every cycle plus directed literal checks.
module tb_penc_sync;

    localparam int N    = 10;
    localparam int DEB  = 4;
    localparam int W    = $clog2(N + 1);
    localparam int NONE = (1 << W) - 1;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] i;
    logic [W-1:0] o;
    logic         any;
    logic         evt_valid;
    logic [W-1:0] evt_code;
    logic         evt_ready;
    logic         ovf;
    logic         ovf_clr;

    int n_tests;
    int n_fail;

    penc_sync #(.N(N), .DEBOUNCE(DEB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i         (i),
        .o         (o),
        .any       (any),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .evt_ready (evt_ready),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference encoder: walk indices p, p-1, ... with modular wrap.
    function automatic int enc(input logic [N-1:0] v, input int p);
        int idx;
        for (int k = 0; k < N; k++) begin
            idx = (p - k + N) % N;
            if (v[idx]) return idx;
        end
        return NONE;
    endfunction

    // Model: stable takes the raw sample once DEB+1 consecutive edge samples agree.
    logic [N-1:0] m_hist [0:DEB];
    logic [N-1:0] m_stable;
    int           m_o, m_code, m_p;
    logic         m_any, m_valid, m_ovf;

    always @(posedge clk or negedge rst_n) begin
        int code;
        bit settled, newe, hs;
        if (!rst_n) begin
            for (int k = 0; k <= DEB; k++) m_hist[k] <= '0;
            m_stable <= '0;
            m_o      <= NONE;
            m_any    <= 1'b0;
            m_valid  <= 1'b0;
            m_code   <= NONE;
            m_ovf    <= 1'b0;
            m_p      <= N - 1;
        end else begin
            code    = enc(m_stable, m_p);
            settled = 1'b1;
            for (int k = 1; k <= DEB; k++) if (m_hist[k] != m_hist[0]) settled = 1'b0;
            if (settled) m_stable <= m_hist[0];
            m_hist[0] <= i;
            for (int k = 1; k <= DEB; k++) m_hist[k] <= m_hist[k-1];
            m_o   <= code;
            m_any <= (m_stable != '0);
            newe  = (code != m_o) && (code != NONE);
            hs    = m_valid && evt_ready;
            if (newe && (!m_valid || hs)) begin
                m_code  <= code;
                m_valid <= 1'b1;
            end else if (hs) begin
                m_valid <= 1'b0;
            end
            if (newe && m_valid && !hs) m_ovf <= 1'b1;
            else if (ovf_clr)           m_ovf <= 1'b0;
`ifdef PENC_ROUND_ROBIN_EN
            if (hs) m_p <= (m_code == 0) ? N - 1 : m_code - 1;
`endif
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("mdl_o", int'(o), m_o);
            chk("mdl_any", int'(any), int'(m_any));
            chk("mdl_evt_valid", int'(evt_valid), int'(m_valid));
            chk("mdl_evt_code", int'(evt_code), m_code);
            chk("mdl_ovf", int'(ovf), int'(m_ovf));
        end
    end

    int got[$];

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        i         = '0;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        tick(3);
        chk("rst_o", int'(o), 15);
        chk("rst_evt_code", int'(evt_code), 15);
        chk("rst_evt_valid", int'(evt_valid), 0);
        rst_n = 1'b1;

        // Single line and exact latency
        i = 10'b0000100000;
        tick(6);
        chk("lat_before_o", int'(o), 15);
        chk("lat_before_valid", int'(evt_valid), 0);
        tick(1);
        chk("single_o", int'(o), 5);
        chk("single_any", int'(any), 1);
        chk("single_valid", int'(evt_valid), 1);
        chk("single_code", int'(evt_code), 5);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        $display("[TB] single line event accepted, code=5 expected");
        chk("single_accept", int'(evt_valid), 0);

        // Asynchronous reset with an event pending
        i = 10'b0000001000;
        tick(10);
        chk("pend_valid", int'(evt_valid), 1);
        chk("pend_code", int'(evt_code), 3);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_o", int'(o), 15);
        chk("arst_any", int'(any), 0);
        chk("arst_valid", int'(evt_valid), 0);
        chk("arst_code", int'(evt_code), 15);
        chk("arst_ovf", int'(ovf), 0);
        tick(2);
        rst_n = 1'b1;

        // Priority, then release
        i = 10'b1000000001;
        tick(6);
        chk("prio_before_o", int'(o), 15);
        tick(1);
        chk("prio_o", int'(o), 9);
        chk("prio_code", int'(evt_code), 9);
        i = '0;
        tick(10);
        chk("rel_o", int'(o), 15);
        chk("rel_any", int'(any), 0);
        chk("rel_code", int'(evt_code), 9);
        chk("rel_no_ovf", int'(ovf), 0);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        chk("prio_accept", int'(evt_valid), 0);

        // Glitch reject
        i = 10'b0000000100;
        tick(3);
        i = '0;
        tick(12);
        chk("glitch_o", int'(o), 15);
        chk("glitch_valid", int'(evt_valid), 0);

        // Overflow under backpressure
        i = 10'b0000001000;
        tick(10);
        chk("ovf_first_code", int'(evt_code), 3);
        i = 10'b0010000000;
        tick(10);
        chk("ovf_o", int'(o), 7);
        chk("ovf_code_held", int'(evt_code), 3);
        chk("ovf_set", int'(ovf), 1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        chk("ovf_clr", int'(ovf), 0);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        chk("ovf_accept", int'(evt_valid), 0);
        i = '0;
        tick(10);

        // Several lines held with the consumer always ready
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        i         = 10'b0100010010;
        evt_ready = 1'b1;
        for (int c = 0; c < 24; c++) begin
            tick(1);
            if (evt_valid) begin
                got.push_back(int'(evt_code));
                $display("[TB] evt accepted code=%0d", evt_code);
            end
        end
        evt_ready = 1'b0;
`ifdef PENC_ROUND_ROBIN_EN
        chk("rr_count_ge4", int'(got.size() >= 4), 1);
        if (got.size() >= 4) begin
            chk("rr_0", got[0], 8);
            chk("rr_1", got[1], 4);
            chk("rr_2", got[2], 1);
            chk("rr_3", got[3], 8);
        end
`else
        chk("fixed_count", got.size(), 1);
        if (got.size() >= 1) chk("fixed_code", got[0], 8);
`endif
        i = '0;
        tick(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
